// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the fetch sequencer
package fetch_pkg;

  localparam int PC_W = 32;
  localparam logic [PC_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam int unsigned PC_STEP_DEFAULT = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_HOLD   = 2'd2,
    ST_HALTED = 2'd3
  } fetch_state_e;

  typedef enum logic [1:0] {
    PC_SEL_HOLD  = 2'd0,
    PC_SEL_SEQ   = 2'd1,
    PC_SEL_REDIR = 2'd2
  } pc_sel_e;

  // Instruction addresses are word aligned; low two bits of any target are dropped.
  function automatic logic [PC_W-1:0] align_pc(input logic [PC_W-1:0] a);
    return a & ~PC_W'(3);
  endfunction

endpackage

// File: rtl/pc_next_sel.sv
// rtl/pc_next_sel.sv - combinational next-PC mux (hold / sequential / redirect)
module pc_next_sel
  import fetch_pkg::*;
#(
  parameter int unsigned PC_STEP = PC_STEP_DEFAULT
) (
  input  logic [1:0]      sel,
  input  logic [PC_W-1:0] cur_pc,
  input  logic [PC_W-1:0] redirect_target,
  output logic [PC_W-1:0] next_pc
);

  logic [PC_W-1:0] seq_pc;

  // Sequential successor wraps naturally modulo 2^32.
  assign seq_pc = cur_pc + PC_W'(PC_STEP);

  // Pick the next PC; unused encodings hold the current value.
  always_comb begin
    next_pc = cur_pc;
    case (sel)
      PC_SEL_SEQ:   next_pc = seq_pc;
      PC_SEL_REDIR: next_pc = align_pc(redirect_target);
      default:      next_pc = cur_pc;
    endcase
  end

endmodule

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - fetch-stage PC owner and imem req/ack sequencer
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int unsigned PC_STEP  = PC_STEP_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  input  logic        if_ready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic [1:0]  state_o
);

  localparam logic [1:0] S_IDLE   = ST_IDLE;
  localparam logic [1:0] S_FETCH  = ST_FETCH;
  localparam logic [1:0] S_HOLD   = ST_HOLD;
  localparam logic [1:0] S_HALTED = ST_HALTED;

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        redir_pend_q;
  logic [31:0] redir_pc_q;
  logic [1:0]  pc_sel;
  logic        use_pend_target;
  logic        capture;
  logic        squash;
  logic        set_pend;
  logic        clr_pend;
  logic [31:0] redirect_target;

  // A redirect seen during an outstanding request is parked and applied when the ack arrives.
  assign redirect_target = use_pend_target ? redir_pc_q : redirect_pc;

  pc_next_sel #(
    .PC_STEP(PC_STEP)
  ) u_pc_next_sel (
    .sel             (pc_sel),
    .cur_pc          (pc_q),
    .redirect_target (redirect_target),
    .next_pc         (pc_d)
  );

  assign imem_req  = (state_q == S_FETCH);
  assign imem_addr = pc_q;
  assign state_o   = state_q;

  // Next-state and datapath control decode.
  always_comb begin
    state_d         = state_q;
    pc_sel          = PC_SEL_HOLD;
    use_pend_target = 1'b0;
    capture         = 1'b0;
    squash          = 1'b0;
    set_pend        = 1'b0;
    clr_pend        = 1'b0;
    case (state_q)
      S_IDLE: begin
        state_d = halt ? S_HALTED : S_FETCH;
      end
      S_FETCH: begin
        if (imem_ack) begin
          clr_pend = 1'b1;
          if (redirect_valid) begin
            // Fresh redirect is newer than anything parked.
            pc_sel = PC_SEL_REDIR;
          end else if (redir_pend_q) begin
            pc_sel          = PC_SEL_REDIR;
            use_pend_target = 1'b1;
          end else begin
            capture = 1'b1;
            pc_sel  = PC_SEL_SEQ;
            state_d = S_HOLD;
          end
        end else if (redirect_valid) begin
          // Address must stay stable while requesting, so only remember the target.
          set_pend = 1'b1;
        end
      end
      S_HOLD: begin
        if (redirect_valid) begin
          squash  = 1'b1;
          pc_sel  = PC_SEL_REDIR;
          state_d = halt ? S_HALTED : S_FETCH;
        end else if (if_ready) begin
          squash  = 1'b1;
          state_d = halt ? S_HALTED : S_FETCH;
        end
      end
      S_HALTED: begin
        if (redirect_valid) begin
          pc_sel = PC_SEL_REDIR;
        end
        if (!halt) begin
          state_d = S_FETCH;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, PC, parked redirect and IF/ID holding registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      pc_q         <= RESET_PC;
      redir_pend_q <= 1'b0;
      redir_pc_q   <= 32'h0;
      if_valid     <= 1'b0;
      if_instr     <= 32'h0;
      if_pc        <= 32'h0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      if (set_pend) begin
        redir_pend_q <= 1'b1;
        redir_pc_q   <= redirect_pc;
      end else if (clr_pend) begin
        redir_pend_q <= 1'b0;
      end
      if (capture) begin
        if_valid <= 1'b1;
        if_instr <= imem_rdata;
        if_pc    <= pc_q;
      end else if (squash) begin
        if_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - directed vector table plus randomized model check for fetch_sequencer
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        if_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt;
  logic [1:0]  state_o;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  fetch_sequencer #(
    .RESET_PC(32'h0000_0000),
    .PC_STEP (4)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .if_valid       (if_valid),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .if_ready       (if_ready),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt           (halt),
    .state_o        (state_o)
  );

  typedef struct {
    logic        req;
    logic [31:0] addr;
    logic        vld;
    logic [31:0] instr;
    logic [31:0] ipc;
    logic [1:0]  st;
    logic        rst;
    logic        ack;
    logic [31:0] rdata;
    logic        rdy;
    logic        rv;
    logic [31:0] rpc;
    logic        hlt;
  } vec_t;

  vec_t tbl[$];

  // Behavioural reference: fetch engine described by what it is doing, not by a state code.
  logic [31:0] m_pc;
  bit          m_boot;
  bit          m_fetching;
  bit          m_halted;
  logic [31:0] m_pend[$];
  logic [63:0] m_held[$];
  logic [31:0] m_if_instr;
  logic [31:0] m_if_pc;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'hC3A5, a[31:16] + 16'h0101};
  endfunction

  function automatic logic [1:0] m_state();
    if (m_boot) return 2'd0;
    if (m_fetching) return 2'd1;
    if (m_held.size() != 0) return 2'd2;
    return 2'd3;
  endfunction

  task automatic model_step();
    logic [31:0] tgt;
    if (reset) begin
      m_pc = 32'h0; m_boot = 1; m_fetching = 0; m_halted = 0;
      m_pend.delete(); m_held.delete(); m_if_instr = 32'h0; m_if_pc = 32'h0;
    end else if (m_boot) begin
      m_boot = 0;
      if (halt) m_halted = 1; else m_fetching = 1;
    end else if (m_fetching) begin
      if (imem_ack) begin
        if (redirect_valid || m_pend.size() != 0) begin
          tgt = redirect_valid ? redirect_pc : m_pend[0];
          m_pc = {tgt[31:2], 2'b00};
          m_pend.delete();
        end else begin
          m_held.push_back({imem_rdata, m_pc});
          m_if_instr = imem_rdata;
          m_if_pc = m_pc;
          m_pc = m_pc + 32'd4;
          m_fetching = 0;
        end
      end else if (redirect_valid) begin
        m_pend.delete();
        m_pend.push_back(redirect_pc);
      end
    end else if (m_held.size() != 0) begin
      if (redirect_valid || if_ready) begin
        m_held.delete();
        if (redirect_valid) m_pc = {redirect_pc[31:2], 2'b00};
        if (halt) m_halted = 1; else m_fetching = 1;
      end
    end else if (m_halted) begin
      if (redirect_valid) m_pc = {redirect_pc[31:2], 2'b00};
      if (!halt) begin
        m_halted = 0;
        m_fetching = 1;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic check(input string name, input int cyc, input logic ereq, input logic [31:0] eaddr,
                       input logic evld, input logic [31:0] einstr, input logic [31:0] epc,
                       input logic [1:0] est);
    n_checks++;
    if ({imem_req, imem_addr, if_valid, if_instr, if_pc, state_o} ===
        {ereq, eaddr, evld, einstr, epc, est}) begin
      n_pass++;
    end else begin
      $display("FAIL %s cyc %0d: got req=%0b addr=%h valid=%0b instr=%h pc=%h state=%0d, expected req=%0b addr=%h valid=%0b instr=%h pc=%h state=%0d",
               name, cyc, imem_req, imem_addr, if_valid, if_instr, if_pc, state_o,
               ereq, eaddr, evld, einstr, epc, est);
    end
  endtask

  task automatic row(input logic req, input logic [31:0] addr, input logic vld, input logic [31:0] instr,
                     input logic [31:0] ipc, input logic [1:0] st,
                     input logic rst, input logic ack, input logic [31:0] rdata, input logic rdy,
                     input logic rv, input logic [31:0] rpc, input logic hlt);
    vec_t v;
    v.req = req; v.addr = addr; v.vld = vld; v.instr = instr; v.ipc = ipc; v.st = st;
    v.rst = rst; v.ack = ack; v.rdata = rdata; v.rdy = rdy; v.rv = rv; v.rpc = rpc; v.hlt = hlt;
    tbl.push_back(v);
  endtask

  localparam logic [31:0] J  = 32'hBAD0_0000;
  localparam logic [31:0] I0 = 32'h1111_0000;
  localparam logic [31:0] I1 = 32'h2222_0004;
  localparam logic [31:0] I2 = 32'h3333_0008;
  localparam logic [31:0] IA = 32'h4444_0100;
  localparam logic [31:0] IB = 32'h8C01_0004;
  localparam logic [31:0] IC = 32'h5555_0008;
  localparam logic [31:0] ID = 32'h6666_FFFC;
  localparam logic [31:0] IE = 32'h7777_0000;
  localparam logic [31:0] IF = 32'h1234_5678;

  initial begin
    reset = 1'b1; imem_ack = 1'b0; imem_rdata = J; if_ready = 1'b0;
    redirect_valid = 1'b0; redirect_pc = 32'h0; halt = 1'b0;
    @(negedge clk);
    step();
    step();

    // expected outputs this cycle | inputs applied this cycle
    row(0, 32'h0,   0, 32'h0, 32'h0, 2'd0,  0, 0, J,  0, 0, 32'h0, 0);
    row(1, 32'h0,   0, 32'h0, 32'h0, 2'd1,  0, 0, J,  0, 0, 32'h0, 0);
    row(1, 32'h0,   0, 32'h0, 32'h0, 2'd1,  0, 1, I0, 0, 0, 32'h0, 0);
    row(0, 32'h4,   1, I0,    32'h0, 2'd2,  0, 0, J,  1, 0, 32'h0, 0);
    row(1, 32'h4,   0, I0,    32'h0, 2'd1,  0, 0, J,  0, 0, 32'h0, 0);
    row(1, 32'h4,   0, I0,    32'h0, 2'd1,  0, 1, I1, 0, 0, 32'h0, 0);
    row(0, 32'h8,   1, I1,    32'h4, 2'd2,  0, 0, J,  1, 0, 32'h0, 0);
    row(1, 32'h8,   0, I1,    32'h4, 2'd1,  0, 0, J,  0, 0, 32'h0, 0);
    row(1, 32'h8,   0, I1,    32'h4, 2'd1,  0, 1, I2, 0, 0, 32'h0, 0);
    row(0, 32'hC,   1, I2,    32'h8, 2'd2,  0, 0, J,  1, 0, 32'h0, 0);
    row(1, 32'hC,   0, I2,    32'h8, 2'd1,  0, 0, J,  0, 0, 32'h0, 0);
    row(1, 32'hC,   0, I2,    32'h8, 2'd1,  0, 0, J,  0, 1, 32'h100, 0);
    row(1, 32'hC,   0, I2,    32'h8, 2'd1,  0, 0, J,  0, 0, 32'h0, 0);
    row(1, 32'hC,   0, I2,    32'h8, 2'd1,  0, 1, 32'hDEAD_BEEF, 0, 0, 32'h0, 0);
    row(1, 32'h100, 0, I2,    32'h8, 2'd1,  0, 1, IA, 0, 0, 32'h0, 0);
    row(0, 32'h104, 1, IA,  32'h100, 2'd2,  0, 0, J,  1, 1, 32'h203, 0);
    row(1, 32'h200, 0, IA,  32'h100, 2'd1,  0, 0, J,  0, 1, 32'h7777_0000, 0);
    row(1, 32'h200, 0, IA,  32'h100, 2'd1,  0, 1, J,  0, 1, 32'h5, 0);
    row(1, 32'h4,   0, IA,  32'h100, 2'd1,  0, 1, IB, 0, 0, 32'h0, 0);
    row(0, 32'h8,   1, IB,    32'h4, 2'd2,  0, 0, J,  0, 0, 32'h0, 0);
    row(0, 32'h8,   1, IB,    32'h4, 2'd2,  0, 0, J,  0, 0, 32'h0, 1);
    row(0, 32'h8,   1, IB,    32'h4, 2'd2,  0, 0, J,  0, 0, 32'h0, 0);
    row(0, 32'h8,   1, IB,    32'h4, 2'd2,  0, 0, J,  0, 0, 32'h0, 0);
    row(0, 32'h8,   1, IB,    32'h4, 2'd2,  0, 0, J,  1, 0, 32'h0, 0);
    row(1, 32'h8,   0, IB,    32'h4, 2'd1,  0, 1, IC, 0, 0, 32'h0, 0);
    row(0, 32'hC,   1, IC,    32'h8, 2'd2,  0, 0, J,  0, 1, 32'hFFFF_FFFE, 0);
    row(1, 32'hFFFF_FFFC, 0, IC, 32'h8, 2'd1, 0, 1, ID, 0, 0, 32'h0, 0);
    row(0, 32'h0,   1, ID, 32'hFFFF_FFFC, 2'd2, 0, 0, J, 1, 0, 32'h0, 0);
    row(1, 32'h0,   0, ID, 32'hFFFF_FFFC, 2'd1, 0, 0, J, 0, 0, 32'h0, 1);
    row(1, 32'h0,   0, ID, 32'hFFFF_FFFC, 2'd1, 0, 1, IE, 0, 0, 32'h0, 1);
    row(0, 32'h4,   1, IE,    32'h0, 2'd2,  0, 0, J,  1, 0, 32'h0, 1);
    row(0, 32'h4,   0, IE,    32'h0, 2'd3,  0, 0, J,  0, 0, 32'h0, 1);
    row(0, 32'h4,   0, IE,    32'h0, 2'd3,  0, 0, J,  0, 0, 32'h0, 0);
    row(1, 32'h4,   0, IE,    32'h0, 2'd1,  0, 0, J,  0, 0, 32'h0, 0);
    row(1, 32'h4,   0, IE,    32'h0, 2'd1,  1, 0, J,  0, 0, 32'h0, 0);
    row(0, 32'h0,   0, 32'h0, 32'h0, 2'd0,  0, 1, J,  0, 0, 32'h0, 0);
    row(1, 32'h0,   0, 32'h0, 32'h0, 2'd1,  0, 1, IF, 0, 0, 32'h0, 0);
    row(0, 32'h4,   1, IF,    32'h0, 2'd2,  0, 0, J,  1, 0, 32'h0, 0);
    row(1, 32'h4,   0, IF,    32'h0, 2'd1,  1, 0, J,  0, 0, 32'h0, 1);
    row(0, 32'h0,   0, 32'h0, 32'h0, 2'd0,  0, 0, J,  0, 0, 32'h0, 1);
    row(0, 32'h0,   0, 32'h0, 32'h0, 2'd3,  0, 0, J,  0, 0, 32'h0, 0);
    row(1, 32'h0,   0, 32'h0, 32'h0, 2'd1,  0, 0, J,  0, 0, 32'h0, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      check("vec", i, tbl[i].req, tbl[i].addr, tbl[i].vld, tbl[i].instr, tbl[i].ipc, tbl[i].st);
      reset = tbl[i].rst; imem_ack = tbl[i].ack; imem_rdata = tbl[i].rdata;
      if_ready = tbl[i].rdy; redirect_valid = tbl[i].rv; redirect_pc = tbl[i].rpc; halt = tbl[i].hlt;
      step();
    end

    halt = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      check("rand", c, m_fetching, m_pc, (m_held.size() != 0), m_if_instr, m_if_pc, m_state());
      reset = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 19) == 0) halt = ~halt;
      imem_ack = m_fetching && ($urandom_range(0, 2) == 0);
      imem_rdata = imem_ack ? mem_word(m_pc) : $urandom;
      if_ready = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 11) == 0);
      redirect_pc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                : $urandom;
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
